// File: rtl/fft_power_peak.sv
// ---------------------------------------------------------------------------
// fft_power_peak
//
// Downstream stage of the 256-point FFT. It consumes the bit-reversed output
// stream, one complex bin per valid cycle, and computes the power of each bin
// as re^2 + im^2. For every frame it reports the index and power of the
// strongest bin and the total energy. Back-to-back frames are supported.
//
// Parameters
//   N    bins per frame (power of two)
//   LDN  log2(N); width of the bin indices
//   W    input sample width (signed two's complement)
//
// Ports
//   clk         system clock; all logic runs on the rising edge
//   reset       asynchronous, active-high
//   in_valid    in_re/in_im carry one bin this cycle
//   in_re       bin real part, signed
//   in_im       bin imaginary part, signed
//   pwr_valid   pwr_out/pwr_bin are valid this cycle
//   pwr_out     re^2 + im^2, unsigned
//   pwr_bin     bin index of pwr_out
//   frame_done  one-cycle pulse: peak_*/energy now hold a new frame
//   peak_bin    index of the strongest bin of the last completed frame
//   peak_pwr    power of that bin
//   energy      sum of all N bin powers of the last completed frame
//   frame_cnt   completed-frame count; wraps from 0xFFFF to 0
// ---------------------------------------------------------------------------
module fft_power_peak #(
  parameter int unsigned N   = 256,
  parameter int unsigned LDN = 8,
  parameter int unsigned W   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [W-1:0]         in_re,
  input  logic [W-1:0]         in_im,
  output logic                 pwr_valid,
  output logic [2*W-1:0]       pwr_out,
  output logic [LDN-1:0]       pwr_bin,
  output logic                 frame_done,
  output logic [LDN-1:0]       peak_bin,
  output logic [2*W-1:0]       peak_pwr,
  output logic [2*W+LDN-1:0]   energy,
  output logic [15:0]          frame_cnt
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACC    = 2'd1;
  localparam logic [1:0] ST_REPORT = 2'd2;

  // -------------------------------------------------------------------------
  // Bin counter. Frame boundaries come only from counting accepted samples;
  // the data itself is never inspected.
  // -------------------------------------------------------------------------
  logic [LDN-1:0] r_bin;
  logic           w_last;

  assign w_last = (r_bin == LDN'(N-1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin <= '0;
    end else if (in_valid) begin
      r_bin <= w_last ? '0 : r_bin + LDN'(1);
    end
  end

  // -------------------------------------------------------------------------
  // Stage 1: square each component.
  // Operands are sign-extended to 2W bits, so the low 2W bits of the product
  // are the exact (non-negative) square, at most 2^(2W-2).
  // -------------------------------------------------------------------------
  logic signed [2*W-1:0] w_re_ext;
  logic signed [2*W-1:0] w_im_ext;
  logic                  r_s1_valid;
  logic [2*W-1:0]        r_sq_re;
  logic [2*W-1:0]        r_sq_im;
  logic [LDN-1:0]        r_s1_bin;
  logic                  r_s1_last;

  assign w_re_ext = {{W{in_re[W-1]}}, in_re};
  assign w_im_ext = {{W{in_im[W-1]}}, in_im};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1_valid <= 1'b0;
      r_sq_re    <= '0;
      r_sq_im    <= '0;
      r_s1_bin   <= '0;
      r_s1_last  <= 1'b0;
    end else begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_sq_re   <= w_re_ext * w_re_ext;
        r_sq_im   <= w_im_ext * w_im_ext;
        r_s1_bin  <= r_bin;
        r_s1_last <= w_last;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Stage 2: power = sum of squares. The maximum is 2 * 2^(2W-2) = 2^(2W-1),
  // which fits the unsigned 2W-bit result exactly.
  // Output data holds its last value while pwr_valid is low.
  // -------------------------------------------------------------------------
  logic [2*W-1:0] w_pwr;
  logic           r_s2_last;

  assign w_pwr = r_sq_re + r_sq_im;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pwr_valid <= 1'b0;
      pwr_out   <= '0;
      pwr_bin   <= '0;
      r_s2_last <= 1'b0;
    end else begin
      pwr_valid <= r_s1_valid;
      if (r_s1_valid) begin
        pwr_out   <= w_pwr;
        pwr_bin   <= r_s1_bin;
        r_s2_last <= r_s1_last;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Peak / energy tracker, driven by the stage-2 output.
  // In IDLE and REPORT a valid sample is the first bin of a frame and loads
  // the running values; in ACC it accumulates. A strict compare keeps the
  // lowest index on ties. When the sample carries the last tag, the final
  // values (last bin included) go straight to the result registers so they
  // are already stable while frame_done is high.
  // -------------------------------------------------------------------------
  logic [1:0]           r_state;
  logic [2*W-1:0]       r_run_peak;
  logic [LDN-1:0]       r_run_bin;
  logic [2*W+LDN-1:0]   r_run_energy;

  logic                 w_first;
  logic                 w_take;
  logic [2*W+LDN-1:0]   w_pwr_ext;
  logic [2*W-1:0]       w_nxt_peak;
  logic [LDN-1:0]       w_nxt_bin;
  logic [2*W+LDN-1:0]   w_nxt_energy;

  always_comb begin
    w_first      = (r_state != ST_ACC);
    w_pwr_ext    = {{LDN{1'b0}}, pwr_out};
    w_take       = w_first || (pwr_out > r_run_peak);
    w_nxt_peak   = w_take ? pwr_out : r_run_peak;
    w_nxt_bin    = w_take ? pwr_bin : r_run_bin;
    w_nxt_energy = w_first ? w_pwr_ext : (r_run_energy + w_pwr_ext);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_run_peak   <= '0;
      r_run_bin    <= '0;
      r_run_energy <= '0;
      peak_bin     <= '0;
      peak_pwr     <= '0;
      energy       <= '0;
      frame_cnt    <= '0;
    end else begin
      if (pwr_valid) begin
        r_run_peak   <= w_nxt_peak;
        r_run_bin    <= w_nxt_bin;
        r_run_energy <= w_nxt_energy;
        if (r_s2_last) begin
          peak_bin  <= w_nxt_bin;
          peak_pwr  <= w_nxt_peak;
          energy    <= w_nxt_energy;
          frame_cnt <= frame_cnt + 16'd1;
          r_state   <= ST_REPORT;
        end else begin
          r_state   <= ST_ACC;
        end
      end else if (r_state == ST_REPORT) begin
        r_state <= ST_IDLE;
      end
    end
  end

  // REPORT lasts exactly one cycle unless another last tag follows
  // immediately, which only a single-bin frame could produce.
  assign frame_done = (r_state == ST_REPORT);

endmodule

// File: tb/tb_fft_power_peak.sv
module tb_fft_power_peak;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid;
  logic [15:0]  in_re;
  logic [15:0]  in_im;
  logic         pwr_valid;
  logic [31:0]  pwr_out;
  logic [7:0]   pwr_bin;
  logic         frame_done;
  logic [7:0]   peak_bin;
  logic [31:0]  peak_pwr;
  logic [39:0]  energy;
  logic [15:0]  frame_cnt;

  fft_power_peak #(.N(256), .LDN(8), .W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_re      (in_re),
    .in_im      (in_im),
    .pwr_valid  (pwr_valid),
    .pwr_out    (pwr_out),
    .pwr_bin    (pwr_bin),
    .frame_done (frame_done),
    .peak_bin   (peak_bin),
    .peak_pwr   (peak_pwr),
    .energy     (energy),
    .frame_cnt  (frame_cnt)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Scoreboard of expected per-bin power and the cycle it must appear in.
  typedef struct {
    logic [63:0]  pwr;
    int unsigned  bin;
    int unsigned  due;
  } exp_t;

  exp_t         sb[$];
  int unsigned  fd_q[$];
  int unsigned  tb_bin   = 0;
  int unsigned  fd_count = 0;
  logic         fd_prev  = 1'b0;
  logic [7:0]   snap_bin [0:15];
  logic [31:0]  snap_pwr [0:15];
  logic [39:0]  snap_en  [0:15];

  always @(negedge clk) begin
    if (!reset) begin
      if (pwr_valid) begin
        if (sb.size() == 0) begin
          check("pwr_spurious", pwr_valid, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("pwr_out", pwr_out, e.pwr);
          check("pwr_bin", pwr_bin, e.bin);
          check("pwr_lat", cyc, e.due);
        end
      end else if (sb.size() > 0 && sb[0].due <= cyc) begin
        check("pwr_missing", pwr_valid, 1);
        void'(sb.pop_front());
      end

      if (frame_done) begin
        if (fd_q.size() == 0) begin
          check("fd_spurious", frame_done, 0);
        end else begin
          int unsigned d;
          d = fd_q.pop_front();
          check("fd_lat", cyc, d);
        end
        snap_bin[fd_count % 16] = peak_bin;
        snap_pwr[fd_count % 16] = peak_pwr;
        snap_en[fd_count % 16]  = energy;
        fd_count++;
      end else if (fd_q.size() > 0 && fd_q[0] <= cyc) begin
        check("fd_missing", frame_done, 1);
        void'(fd_q.pop_front());
      end

      if (frame_done && fd_prev) check("fd_width", frame_done, 0);
      fd_prev = frame_done;
    end
  end

  // Drive one bin for one clock (called at a falling edge).
  task automatic send(input int re, input int im);
    exp_t e;
    in_valid = 1'b1;
    in_re    = 16'(re);
    in_im    = 16'(im);
    e.pwr = 64'(longint'(re) * longint'(re) + longint'(im) * longint'(im));
    e.bin = tb_bin;
    e.due = cyc + 2;
    sb.push_back(e);
    if (tb_bin == 255) fd_q.push_back(cyc + 3);
    tb_bin = (tb_bin + 1) % 256;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_done(input int unsigned target);
    int k = 0;
    while (fd_count < target && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("done_wait", fd_count, target);
    idle(3);
    check("done_count", fd_count, target);
  endtask

  task automatic zero_checks();
    check("rst_pwr_valid", pwr_valid, 0);
    check("rst_pwr_out", pwr_out, 0);
    check("rst_pwr_bin", pwr_bin, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_peak_bin", peak_bin, 0);
    check("rst_peak_pwr", peak_pwr, 0);
    check("rst_energy", energy, 0);
    check("rst_frame_cnt", frame_cnt, 0);
  endtask

  int unsigned base;

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    idle(3);
    zero_checks();
    reset = 1'b0;
    idle(2);

    // 1: flat spectrum, ties resolve to bin 0
    for (int k = 0; k < 256; k++) send(100, 0);
    wait_done(1);
    check("t1_peak_bin", peak_bin, 0);
    check("t1_peak_pwr", peak_pwr, 10000);
    check("t1_energy", energy, 2560000);
    check("t1_frame_cnt", frame_cnt, 1);

    // 2: full-scale impulse at bin 37
    for (int k = 0; k < 256; k++) begin
      if (k == 37) send(-32768, -32768);
      else         send(0, 0);
    end
    wait_done(2);
    check("t2_peak_bin", peak_bin, 37);
    check("t2_peak_pwr", peak_pwr, 64'd2147483648);
    check("t2_energy", energy, 64'd2147483648);
    check("t2_frame_cnt", frame_cnt, 2);

    // 4: ramp with random input gaps
    for (int k = 0; k < 256; k++) begin
      send(k, 0);
      if ($urandom_range(0, 1) == 1) idle(1);
    end
    wait_done(3);
    check("t4_peak_bin", peak_bin, 255);
    check("t4_peak_pwr", peak_pwr, 65025);
    check("t4_energy", energy, 5559680);
    check("t4_frame_cnt", frame_cnt, 3);

    // 5: two back-to-back frames with no idle cycle between them
    base = fd_count;
    for (int k = 0; k < 256; k++) send(1, 1);
    for (int k = 0; k < 256; k++) begin
      if (k == 0)      send(10, 0);
      else if (k == 3) send(300, -400);
      else             send(0, 0);
    end
    wait_done(base + 2);
    check("t5a_peak_bin", snap_bin[base % 16], 0);
    check("t5a_peak_pwr", snap_pwr[base % 16], 2);
    check("t5a_energy", snap_en[base % 16], 512);
    check("t5_peak_bin", peak_bin, 3);
    check("t5_peak_pwr", peak_pwr, 250000);
    check("t5_energy", energy, 250100);
    check("t5_frame_cnt", frame_cnt, 5);

    // 6: reset after bin 100, then one clean frame
    base = fd_count;
    for (int k = 0; k <= 100; k++) send(k, k);
    #2 reset = 1'b1;
    #1 zero_checks();
    sb.delete();
    fd_q.delete();
    tb_bin = 0;
    idle(2);
    reset = 1'b0;
    idle(5);
    check("t6_no_partial", fd_count, base);
    for (int k = 0; k < 256; k++) send(0, 255 - k);
    wait_done(base + 1);
    check("t6_peak_bin", peak_bin, 0);
    check("t6_peak_pwr", peak_pwr, 65025);
    check("t6_energy", energy, 5559680);
    check("t6_frame_cnt", frame_cnt, 1);

    idle(5);
    check("sb_empty", sb.size(), 0);
    check("fd_empty", fd_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
